// File: rtl/kbd_event_fifo.sv
// Keyboard press-event FIFO: edge-detects ascii_key, pushes new codes (plus auto-repeat under KBD_TYPEMATIC_EN).
// Latency: push visible on rd_data/count one edge after detection; rd_data is first-word-fall-through.
// Backpressure: none upstream; events arriving while full without a pop are dropped and flag sticky overflow.
module kbd_event_fifo #(
  parameter int DEPTH         = 16,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [7:0]               ascii_key,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("kbd_event_fifo: DEPTH must be a power of two in 2..256");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("kbd_event_fifo: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    prev_key;
  logic          press;
  logic          evt;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  always_comb press = (ascii_key != 8'h00) && (ascii_key != prev_key);

`ifdef KBD_TYPEMATIC_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  localparam int MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXC + 1);

  rpt_state_t    rpt_state;
  logic [CW-1:0] rpt_cnt;
  logic          rpt_fire;

  // rpt_cnt counts cycles since entering DELAY/REPEAT; fire on the last one of the interval.
  always_comb begin
    rpt_fire = 1'b0;
    if (ascii_key != 8'h00 && ascii_key == prev_key) begin
      if (rpt_state == DELAY && rpt_cnt == CW'(REPEAT_DELAY - 1))
        rpt_fire = 1'b1;
      if (rpt_state == REPEAT && rpt_cnt == CW'(REPEAT_PERIOD - 1))
        rpt_fire = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rpt_state <= IDLE;
      rpt_cnt   <= '0;
    end else if (ascii_key == 8'h00) begin
      rpt_state <= IDLE;
      rpt_cnt   <= '0;
    end else if (press) begin
      rpt_state <= DELAY;
      rpt_cnt   <= '0;
    end else if (rpt_fire) begin
      rpt_state <= REPEAT;
      rpt_cnt   <= '0;
    end else if (rpt_state != IDLE) begin
      rpt_cnt   <= rpt_cnt + CW'(1);
    end
  end

  always_comb evt = press | rpt_fire;
`else
  always_comb evt = press;
`endif

  always_comb begin
    empty   = (count == '0);
    full    = (count == CNTW'(DEPTH));
    do_pop  = rd_en && !empty;
    do_push = evt && (!full || do_pop);
    drop    = evt && full && !do_pop;
    rd_data = empty ? 8'h00 : mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      prev_key <= 8'h00;
    end else begin
      prev_key <= ascii_key;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear wins so no lost event goes unreported.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ascii_key;
  end

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Scoreboard bench for kbd_event_fifo; typematic scenario runs only when KBD_TYPEMATIC_EN is defined.
module tb_kbd_event_fifo;

  localparam int DEPTH = 8;

  logic       clk;
  logic       clrn;
  logic [7:0] ascii_key;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       ovf_clr;

  logic [7:0] exp_q[$];
  logic       exp_ovf;
  int         n_pass;
  int         n_total;

  kbd_event_fifo #(.DEPTH(DEPTH), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .clrn(clrn), .ascii_key(ascii_key), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one press (code for one cycle, then released) and records the expected outcome.
  task automatic press(input logic [7:0] code);
    ascii_key = code;
    tick();
    ascii_key = 8'h00;
    tick();
    if (exp_q.size() < DEPTH) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) begin
      n_total++;
      if (rd_data !== exp_q[0] || empty !== 1'b0)
        $display("FAIL %s: rd_data=%h empty=%b, expected rd_data=%h empty=0", name, rd_data, empty, exp_q[0]);
      else n_pass++;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      void'(exp_q.pop_front());
      n_total++;
      if (count !== 4'(exp_q.size()))
        $display("FAIL %s_count: count=%0d expected %0d", name, count, exp_q.size());
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b0 || rd_data !== 8'h00)
      $display("FAIL reset: empty=%b count=%0d overflow=%b rd_data=%h, expected 1/0/0/00", empty, count, overflow, rd_data);
    else n_pass++;
    @(negedge clk);
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_single_press();
    ascii_key = 8'h61;
    tick();
    exp_q.push_back(8'h61);
    n_total++;
    if (count !== 4'd1 || empty !== 1'b0 || rd_data !== 8'h61)
      $display("FAIL single_press: count=%0d empty=%b rd_data=%h, expected 1/0/61", count, empty, rd_data);
    else n_pass++;
    for (int i = 0; i < 9; i++) tick();
    n_total++;
    if (count !== 4'd1)
      $display("FAIL single_hold: count=%0d expected 1", count);
    else n_pass++;
    ascii_key = 8'h00;
    tick();
    drain("single_drain");
  endtask

  task automatic test_abc();
    press(8'h61);
    press(8'h62);
    press(8'h63);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (exp_q.size() > 0) begin
        if (rd_data !== exp_q[0])
          $display("FAIL abc_read%0d: rd_data=%h expected %h", i, rd_data, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
      end else begin
        if (rd_data !== 8'h00 || empty !== 1'b1)
          $display("FAIL abc_empty_read: rd_data=%h empty=%b expected 00/1", rd_data, empty);
        else n_pass++;
      end
      tick();
    end
    rd_en = 1'b0;
    n_total++;
    if (count !== 4'd0 || empty !== 1'b1 || rd_data !== 8'h00)
      $display("FAIL abc_after: count=%0d empty=%b rd_data=%h expected 0/1/00", count, empty, rd_data);
    else n_pass++;
  endtask

  task automatic test_overflow();
    exp_ovf = 1'b0;
    for (int i = 0; i <= DEPTH; i++) press(8'h30 + 8'(i));
    n_total++;
    if (count !== 4'(DEPTH) || overflow !== exp_ovf)
      $display("FAIL overflow_set: count=%0d overflow=%b expected %0d/%b", count, overflow, DEPTH, exp_ovf);
    else n_pass++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_total++;
    if (overflow !== 1'b0)
      $display("FAIL overflow_clr: overflow=%b expected 0", overflow);
    else n_pass++;
    // Drop and clear in the same cycle: overflow must stay set.
    ascii_key = 8'h50;
    ovf_clr = 1'b1;
    tick();
    ascii_key = 8'h00;
    ovf_clr = 1'b0;
    tick();
    n_total++;
    if (overflow !== 1'b1 || count !== 4'(DEPTH))
      $display("FAIL overflow_clr_vs_drop: overflow=%b count=%0d expected 1/%0d", overflow, count, DEPTH);
    else n_pass++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_total++;
    if (overflow !== 1'b0)
      $display("FAIL overflow_clr2: overflow=%b expected 0", overflow);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    ascii_key = 8'h5a;
    rd_en = 1'b1;
    n_total++;
    if (rd_data !== exp_q[0])
      $display("FAIL full_pp_head: rd_data=%h expected %h", rd_data, exp_q[0]);
    else n_pass++;
    tick();
    rd_en = 1'b0;
    ascii_key = 8'h00;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h5a);
    n_total++;
    if (count !== 4'(DEPTH) || overflow !== 1'b0)
      $display("FAIL full_push_pop: count=%0d overflow=%b expected %0d/0", count, overflow, DEPTH);
    else n_pass++;
    tick();
    drain("full_drain");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) press(8'h70 + 8'(i));
    n_total++;
    if (count !== 4'd5)
      $display("FAIL areset_pre: count=%0d expected 5", count);
    else n_pass++;
    ascii_key = 8'h7a;
    #2;
    clrn = 1'b0;
    #1;
    exp_q.delete();
    n_total++;
    if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b0 || rd_data !== 8'h00)
      $display("FAIL areset: empty=%b count=%0d overflow=%b rd_data=%h expected 1/0/0/00", empty, count, overflow, rd_data);
    else n_pass++;
    @(negedge clk);
    clrn = 1'b1;
    tick();
    exp_q.push_back(8'h7a);
    n_total++;
    if (count !== 4'd1 || rd_data !== 8'h7a)
      $display("FAIL held_at_reset: count=%0d rd_data=%h expected 1/7a", count, rd_data);
    else n_pass++;
    ascii_key = 8'h00;
    tick();
    drain("areset_drain");
  endtask

`ifdef KBD_TYPEMATIC_EN
  task automatic test_typematic();
    ascii_key = 8'h41;
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k == 20 || k == 21 || k == 36) begin
        int exp_cnt;
        exp_cnt = 1 + ((k > 20) ? 1 : 0) + ((k > 25) ? 1 : 0) + ((k > 30) ? 1 : 0) + ((k > 35) ? 1 : 0);
        n_total++;
        if (count !== 4'(exp_cnt))
          $display("FAIL typematic_k%0d: count=%0d expected %0d", k, count, exp_cnt);
        else n_pass++;
      end
    end
    ascii_key = 8'h00;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h41);
    for (int i = 0; i < 30; i++) tick();
    n_total++;
    if (count !== 4'd5)
      $display("FAIL typematic_release: count=%0d expected 5", count);
    else n_pass++;
    drain("typematic_drain");
  endtask
`endif

  initial begin
    clrn      = 1'b0;
    ascii_key = 8'h00;
    rd_en     = 1'b0;
    ovf_clr   = 1'b0;
    exp_ovf   = 1'b0;
    n_pass    = 0;
    n_total   = 0;
    test_reset();
    test_single_press();
    test_abc();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
`ifdef KBD_TYPEMATIC_EN
    test_typematic();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
